// File: rtl/fifo_rd_unpack_if.sv
// fifo_rd_unpack_if: FIFO read-side signals and the unpacked byte stream of fifo_rd_unpack.
// master is the unpacker; slave is the FIFO plus downstream consumer.
interface fifo_rd_unpack_if #(
   parameter int CNT_W = 9
);
   logic             wr_full;
   logic             rd_empty;
   logic [15:0]      rd_data;
   logic             rd_req;
   logic [7:0]       out_data;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic             burst_done;
   logic [CNT_W-1:0] word_cnt;

   modport master (
      input  wr_full, rd_empty, rd_data, out_ready,
      output rd_req, out_data, out_valid, busy, burst_done, word_cnt
   );

   modport slave (
      output wr_full, rd_empty, rd_data, out_ready,
      input  rd_req, out_data, out_valid, busy, burst_done, word_cnt
   );
endinterface

// File: rtl/fifo_rd_unpack.sv
// fifo_rd_unpack: drains the mixed-width FIFO in one burst once its full flag is seen,
// and streams each 16-bit word out as two bytes on a valid/ready port.
module fifo_rd_unpack #(
   parameter bit LSB_FIRST = 1'b1,
   parameter int CNT_W     = 9
) (
   input  logic             rd_clk,
   input  logic             sys_rst_n,
   fifo_rd_unpack_if.master bus
);
   typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

   state_t           r_state, w_next;
   logic             r_full_s0, r_full_s1;
   logic             r_inflight, r_hold_v;
   logic [1:0]       r_bcnt;
   logic [15:0]      r_word, r_hold;
   logic [CNT_W-1:0] r_word_cnt;
   logic             w_xfer, w_load, w_rd_req, w_start;
   logic [15:0]      w_src;
   logic [7:0]       w_first, w_second;

   // r_bcnt: 2 = both bytes of r_word pending, 1 = only the second, 0 = empty
   assign w_xfer   = (r_bcnt != 2'd0) && bus.out_ready;
   assign w_load   = (r_bcnt == 2'd0) || ((r_bcnt == 2'd1) && w_xfer);
   assign w_src    = r_hold_v ? r_hold : bus.rd_data;
   assign w_first  = LSB_FIRST ? r_word[7:0] : r_word[15:8];
   assign w_second = LSB_FIRST ? r_word[15:8] : r_word[7:0];

   // A read is issued while the first byte leaves so its word lands exactly as the
   // second byte leaves; r_hold catches the word if the consumer stalls in between.
   always_comb begin
      w_next   = r_state;
      w_rd_req = 1'b0;
      w_start  = 1'b0;
      case (r_state)
         IDLE: begin
            w_start = r_full_s1 && !bus.rd_empty;
            w_next  = w_start ? DRAIN : IDLE;
         end
         DRAIN: begin
            w_rd_req = !bus.rd_empty && !r_inflight && !r_hold_v &&
                       ((r_bcnt == 2'd0) || bus.out_ready);
            w_next   = (bus.rd_empty && !r_inflight && !r_hold_v && (r_bcnt == 2'd0)) ? DONE : DRAIN;
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge rd_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_full_s0  <= 1'b0;
         r_full_s1  <= 1'b0;
         r_state    <= IDLE;
         r_inflight <= 1'b0;
         r_hold_v   <= 1'b0;
         r_hold     <= '0;
         r_word     <= '0;
         r_bcnt     <= 2'd0;
         r_word_cnt <= '0;
      end else begin
         r_full_s0  <= bus.wr_full;
         r_full_s1  <= r_full_s0;
         r_state    <= w_next;
         r_inflight <= w_rd_req;
         if (w_start)
            r_word_cnt <= '0;
         else if (r_inflight && (r_word_cnt != '1))
            r_word_cnt <= r_word_cnt + CNT_W'(1);
         if ((r_inflight || r_hold_v) && w_load) begin
            r_word   <= w_src;
            r_bcnt   <= 2'd2;
            r_hold_v <= 1'b0;
         end else begin
            if (r_inflight) begin
               r_hold   <= bus.rd_data;
               r_hold_v <= 1'b1;
            end
            if (w_xfer)
               r_bcnt <= r_bcnt - 2'd1;
         end
      end
   end

   assign bus.rd_req     = w_rd_req;
   assign bus.out_valid  = r_bcnt != 2'd0;
   assign bus.out_data   = (r_bcnt == 2'd2) ? w_first : (r_bcnt == 2'd1) ? w_second : 8'h00;
   assign bus.busy       = r_state == DRAIN;
   assign bus.burst_done = r_state == DONE;
   assign bus.word_cnt   = r_word_cnt;
endmodule
